// File: rtl/shreg_seq_if.sv
// Command/response bus between a host requester and the shift-register sequencer.
// The requester drives commands and consumes responses; the sequencer does the opposite.
interface shreg_seq_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_cmd;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;

    modport master (
        output in_valid, in_cmd, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_cmd, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shreg_seq.sv
// Sequencer for a W-bit serial-in shift register: load/clear/set/readback,
// then capture the parallel output and flag a mismatch against the expected word.
module shreg_seq #(
    parameter int W   = 4,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         r,
    shreg_seq_if.slave   bus,
    output logic         sd,
    output logic         sh,
    output logic         ds_n,
    output logic         dr_n,
    input  logic [W-1:0] q,
    output logic         busy
);
    localparam int KW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE, SHIFT, GAPW, FORCE, SETTLE, RESP
    } state_t;

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [3:0]    r_gcnt;
    logic          r_fcnt;
    logic [W-1:0]  r_sreg;
    logic [W-1:0]  r_exp;
    logic          r_chk;
    logic          r_rdy;
    logic          r_sd;
    logic          r_sh;
    logic          r_ds_n;
    logic          r_dr_n;
    logic          r_ov;
    logic [W-1:0]  r_od;
    logic          r_err;

    // Command FSM; every datapath strobe and response field is a register.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_gcnt  <= '0;
            r_fcnt  <= 1'b0;
            r_sreg  <= '0;
            r_exp   <= '0;
            r_chk   <= 1'b0;
            r_rdy   <= 1'b0;
            r_sd    <= 1'b0;
            r_sh    <= 1'b0;
            r_ds_n  <= 1'b1;
            r_dr_n  <= 1'b1;
            r_ov    <= 1'b0;
            r_od    <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (bus.in_valid && r_rdy) begin
                        r_rdy <= 1'b0;
                        unique case (bus.in_cmd)
                            2'b00: begin
                                r_state <= SHIFT;
                                r_k     <= '0;
                                r_sh    <= 1'b1;
                                r_sd    <= bus.in_data[W-1];
                                r_sreg  <= {bus.in_data[W-2:0], 1'b0};
                                r_exp   <= bus.in_data;
                                r_chk   <= 1'b1;
                            end
                            2'b01: begin
                                r_state <= FORCE;
                                r_fcnt  <= 1'b0;
                                r_dr_n  <= 1'b0;
                                r_exp   <= '0;
                                r_chk   <= 1'b1;
                            end
                            2'b10: begin
                                r_state <= FORCE;
                                r_fcnt  <= 1'b0;
                                r_ds_n  <= 1'b0;
                                r_exp   <= '1;
                                r_chk   <= 1'b1;
                            end
                            default: begin
                                r_state <= SETTLE;
                                r_chk   <= 1'b0;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    if (r_k == KW'(W - 1)) begin
                        r_sh    <= 1'b0;
                        r_state <= SETTLE;
                    end else if (GAP > 0) begin
                        r_sh    <= 1'b0;
                        r_gcnt  <= '0;
                        r_state <= GAPW;
                    end else begin
                        r_k    <= r_k + 1'b1;
                        r_sh   <= 1'b1;
                        r_sd   <= r_sreg[W-1];
                        r_sreg <= r_sreg << 1;
                    end
                end
                GAPW: begin
                    if (r_gcnt == 4'(GAP - 1)) begin
                        r_state <= SHIFT;
                        r_k     <= r_k + 1'b1;
                        r_sh    <= 1'b1;
                        r_sd    <= r_sreg[W-1];
                        r_sreg  <= r_sreg << 1;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                FORCE: begin
                    if (r_fcnt) begin
                        r_ds_n  <= 1'b1;
                        r_dr_n  <= 1'b1;
                        r_state <= SETTLE;
                    end else begin
                        r_fcnt <= 1'b1;
                    end
                end
                SETTLE: begin
                    r_od    <= q;
                    r_err   <= r_chk && (q != r_exp);
                    r_ov    <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.out_ready) begin
                        r_ov    <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_rdy;
    assign bus.out_valid = r_ov;
    assign bus.out_data  = r_od;
    assign bus.out_err   = r_err;
    assign sd            = r_sd;
    assign sh            = r_sh;
    assign ds_n          = r_ds_n;
    assign dr_n          = r_dr_n;
    assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_shreg_seq.sv
// Bench for shreg_seq: two instances (GAP=0 and GAP=2), each driving a
// behavioural shift register, checked against a command-level reference.
module tb_shreg_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [1:0]        iv, ordy;
    logic [1:0][1:0]   icmd;
    logic [1:0][W-1:0] idat;
    logic [1:0]        ir, ov, oe, sd_w, sh_w, ds_w, dr_w, bz;
    logic [1:0][W-1:0] od, q_w, stuck;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0][W-1:0] mdl;
    bit   [1:0]        mdl_ok;

    for (genvar g = 0; g < 2; g++) begin : u
        shreg_seq_if #(.W(W)) bus ();
        logic [W-1:0] dq;

        assign bus.in_valid  = iv[g];
        assign bus.in_cmd    = icmd[g];
        assign bus.in_data   = idat[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out_data;
        assign oe[g]         = bus.out_err;

        shreg_seq #(.W(W), .GAP(2 * g)) dut (
            .clk  (clk),
            .r    (rst_n),
            .bus  (bus),
            .sd   (sd_w[g]),
            .sh   (sh_w[g]),
            .ds_n (ds_w[g]),
            .dr_n (dr_w[g]),
            .q    (q_w[g]),
            .busy (bz[g])
        );

        always @(posedge clk) begin
            if (!ds_w[g])      dq <= '1;
            else if (!dr_w[g]) dq <= '0;
            else if (sh_w[g])  dq <= {dq[W-2:0], sd_w[g]};
        end

        assign q_w[g] = dq & ~stuck[g];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input int g, input logic [1:0] cmd,
                           input logic [W-1:0] data, input int hold,
                           input bit alt);
        int gp, ov_c, last, t, k_e;
        bit sh_e, err_e, dchk;
        logic [W-1:0] ideal, want;
        gp = 2 * g;
        case (cmd)
            2'd0:    ov_c = 3 + (W - 1) * (gp + 1);
            2'd1:    ov_c = 4;
            2'd2:    ov_c = 4;
            default: ov_c = 2;
        endcase
        last = ov_c + hold;
        @(negedge clk);
        t = 0;
        while (!ir[g] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ir[g]) begin
            chk("rdy_wait", {31'd0, ir[g]}, 1);
            return;
        end
        iv[g] = 1'b1;
        icmd[g] = cmd;
        idat[g] = data;
        ordy[g] = 1'b0;
        case (cmd)
            2'd0: begin mdl[g] = data; mdl_ok[g] = 1'b1; end
            2'd1: begin mdl[g] = '0;   mdl_ok[g] = 1'b1; end
            2'd2: begin mdl[g] = '1;   mdl_ok[g] = 1'b1; end
            default: ;
        endcase
        ideal = mdl[g];
        want  = mdl[g] & ~stuck[g];
        dchk  = mdl_ok[g];
        err_e = (cmd != 2'd3) && (want != ideal);
        @(posedge clk);
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            k_e  = (c - 1) / (gp + 1);
            sh_e = (cmd == 2'd0) && ((c - 1) % (gp + 1) == 0) && (k_e < W);
            chk("sh", {31'd0, sh_w[g]}, {31'd0, sh_e});
            if (sh_e) chk("sd", {31'd0, sd_w[g]}, {31'd0, data[W-1-k_e]});
            chk("dr_n", {31'd0, dr_w[g]}, {31'd0, !(cmd == 2'd1 && c <= 2)});
            chk("ds_n", {31'd0, ds_w[g]}, {31'd0, !(cmd == 2'd2 && c <= 2)});
            chk("ovld", {31'd0, ov[g]}, {31'd0, (c >= ov_c && c <= last)});
            chk("busy", {31'd0, bz[g]}, {31'd0, (c <= last)});
            chk("in_rdy", {31'd0, ir[g]}, {31'd0, (c > last)});
            if (c >= ov_c && c <= last) begin
                if (dchk) chk("odata", {28'd0, od[g]}, {28'd0, want});
                chk("oerr", {31'd0, oe[g]}, {31'd0, err_e});
            end
            if (alt && c <= last) begin
                iv[g] = 1'b1;
                icmd[g] = 2'($urandom);
            end else begin
                iv[g] = 1'b0;
            end
            if (c == last) ordy[g] = 1'b1;
            else if (alt && c < ov_c) ordy[g] = 1'($urandom);
            else ordy[g] = 1'b0;
        end
    endtask

    initial begin
        int t;
        stuck  = '0;
        iv     = '0;
        ordy   = '0;
        icmd   = '0;
        idat   = '0;
        mdl    = '0;
        mdl_ok = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, ir[0]}, 0);
        chk("rst_sh", {31'd0, sh_w[0]}, 0);
        chk("rst_sd", {31'd0, sd_w[0]}, 0);
        chk("rst_dsn", {31'd0, ds_w[0]}, 1);
        chk("rst_drn", {31'd0, dr_w[0]}, 1);
        chk("rst_ov", {31'd0, ov[0]}, 0);
        chk("rst_od", {28'd0, od[0]}, 0);
        chk("rst_oe", {31'd0, oe[0]}, 0);
        chk("rst_busy", {31'd0, bz[0]}, 0);
        rst_n = 1'b1;

        run_cmd(0, 2'd0, 4'b1011, 0, 1'b0);
        run_cmd(0, 2'd1, 4'b0000, 0, 1'b0);
        run_cmd(0, 2'd3, 4'b0000, 0, 1'b0);
        stuck[0] = 4'b0100;
        run_cmd(0, 2'd2, 4'b0000, 0, 1'b0);
        stuck[0] = '0;
        run_cmd(1, 2'd0, 4'b0110, 0, 1'b0);
        run_cmd(0, 2'd0, 4'b1100, 5, 1'b1);
        run_cmd(0, 2'd2, 4'b0000, 5, 1'b1);
        run_cmd(1, 2'd3, 4'b0000, 5, 1'b1);

        @(negedge clk);
        t = 0;
        while (!ir[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_rdy", {31'd0, ir[0]}, 1);
        iv[0] = 1'b1;
        icmd[0] = 2'd0;
        idat[0] = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_sh3", {31'd0, sh_w[0]}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_sh", {31'd0, sh_w[0]}, 0);
        chk("abort_dsn", {31'd0, ds_w[0]}, 1);
        chk("abort_drn", {31'd0, dr_w[0]}, 1);
        chk("abort_ov", {31'd0, ov[0]}, 0);
        chk("abort_busy", {31'd0, bz[0]}, 0);
        chk("abort_rdy0", {31'd0, ir[0]}, 0);
        mdl_ok[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(0, 2'd3, 4'b0000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 1)), 2'($urandom), W'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
